three_level_modulator: RTL
==========================

Name: three_level_modulator

Overview:
- Parametrised successor of the fixed-rate three-level full-bridge command generator.
- Produces the four gate commands (M0/M2 = leg A high/low, M1/M3 = leg B high/low) for a +1 / 0 / -1 / 0 waveform.
  - Half-period and zero-state width are runtime-programmable.
  - Per-leg dead time is inserted on every switch transition.
  - Start/stop is graceful.
- Sits between the hybrid-control logic and the gate-driver pins; o_sigma feeds the controller as the applied-level estimate.

Parameters:
- CNT_W, 16, width of the half-period, zero-time and segment counters.
- DT_W, 8, width of the dead-time input and counter.
- SIGMA_W, 32, width of the signed o_sigma output.

Ports:
- i_CLK  in  1  system clock.
- i_RST_n  in  1  synchronous reset, active low.
- i_EN  in  1  run request.
- i_HALF_PERIOD  in  CNT_W  cycles per half period (+1 segment plus zero segment).
- i_ZERO_TIME  in  CNT_W  cycles of zero state per half period.
- i_DEAD_TIME  in  DT_W  dead-time cycles per leg transition.
- o_MOSFET  out  4  gate commands [M3 M2 M1 M0], active high.
- o_sigma  out  SIGMA_W  commanded level: +1, 0 or -1, two's complement, sign-extended.
- o_BUSY  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered. On reset: state IDLE, o_MOSFET=0, o_sigma=0, o_BUSY=0, all counters 0.
- FSM states: IDLE -> POS -> ZERO_A -> NEG -> ZERO_B -> POS ...
  - IDLE -> POS when i_EN=1 is sampled.
  - At the end of ZERO_B: go to IDLE if i_EN=0, else POS.
  - i_EN low mid-period has no effect until the end of ZERO_B. The period always completes.
- Latching: i_HALF_PERIOD, i_ZERO_TIME and i_DEAD_TIME are latched on every entry to POS, and held constant for the whole period.
- Clamping, applied to latched values:
  - HALF_eff = max(HALF,2).
  - ZERO_eff = min(ZERO, HALF_eff-1).
  - POS and NEG last HALF_eff-ZERO_eff cycles; ZERO_A and ZERO_B last ZERO_eff cycles each.
  - If ZERO_eff=0, both zero states are skipped (two-level output: POS->NEG->POS).
  - Period = 2*HALF_eff cycles.
- Target switch sets:
  - POS: M0, M3.
  - ZERO_A / ZERO_B: M0, M1.
  - NEG: M1, M2.
  - IDLE: none.
- o_sigma values: POS = +1; ZERO_A / ZERO_B / IDLE = 0; NEG = -1 (all ones).
- Dead time:
  - Each state transition changes exactly one leg (or both when entering from IDLE, or on a skipped-zero POS<->NEG transition).
  - The outgoing switch drops in the first cycle of the new state.
  - The incoming switch asserts after DT_eff cycles within that state.
  - Switches on an unchanged leg are never deasserted.
  - If DT >= segment length, the incoming switch stays off for the whole segment.
  - M0&M2 and M1&M3 are never simultaneously high, under all inputs.
- Timing: i_EN sampled high in IDLE at cycle N gives state POS and o_sigma=+1 at N+1, and M0/M3 high at N+1+DT_eff. With DT=0, at N+1.
- o_sigma changes in the first cycle of each state, independent of dead time.
- Going to IDLE: o_MOSFET=0 and o_sigma=0 in the first IDLE cycle.
- Reset asserted mid-operation: the next cycle is IDLE with all gates off. No dead-time completion.

Optional Feature:
- Macro THREE_LEVEL_SYNC_EN.
- When defined: adds output o_SYNC (1 bit, reset 0). It pulses high for exactly one cycle in the first cycle of every POS entry, for scope triggering and controller phase alignment.
- When undefined: the port does not exist, and no logic is generated.

Decomposition:
- Package three_level_pkg:
  - state enum (IDLE, POS, ZERO_A, NEG, ZERO_B);
  - the 4-bit switch-pattern constants per state;
  - SIGMA level constants.
- One natural sub-module, deadtime_leg. It is instantiated twice (leg A, leg B):
  - Inputs: target high/low request, latched dead time.
  - Outputs: gated high/low commands.
  - It contains the DT counter.

Test Plan:
- Reset with i_EN=1 held -> o_MOSFET=0, o_sigma=0 during reset. After release: sigma sequence +1×6, 0×2, -1×6, 0×2 repeating, with HALF=8, ZERO=2, DT=0.
- HALF=8, ZERO=2, DT=3 -> on entry to ZERO_A, M3 drops at once and M1 rises 3 cycles later. Per half period: sigma/pattern checked, no shoot-through ever.
- ZERO=0, HALF=5 -> two-level output (period 10), no zero states. Checker confirms both legs switch with DT gap.
- i_EN dropped mid-NEG -> NEG and ZERO_B complete, IDLE entered after ZERO_B, o_MOSFET=0, o_BUSY=0. Re-enable restarts in POS.
- i_HALF_PERIOD changed from 8 to 4 mid-period -> current period keeps 16 cycles, next period 8 cycles. ZERO=6 with HALF=4 clamps to 3.
- THREE_LEVEL_SYNC_EN defined -> o_SYNC single-cycle pulse exactly at each POS entry, spacing 2*HALF_eff. Reset mid-POS -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/three_level_pkg.sv
// Shared state encoding, per-state gate patterns and sigma levels for the three-level modulator.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: none.
package three_level_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POS    = 3'd1,
    ZERO_A = 3'd2,
    NEG    = 3'd3,
    ZERO_B = 3'd4
  } state_t;

  // Target gate patterns, bit order [M3 M2 M1 M0]
  localparam logic [3:0] PAT_IDLE = 4'b0000;
  localparam logic [3:0] PAT_POS  = 4'b1001;  // M0 + M3
  localparam logic [3:0] PAT_ZERO = 4'b0011;  // M0 + M1
  localparam logic [3:0] PAT_NEG  = 4'b0110;  // M1 + M2

  // Two-bit signed levels, sign-extended to the output width at the top
  localparam logic [1:0] SIG_ZERO = 2'b00;
  localparam logic [1:0] SIG_POS  = 2'b01;
  localparam logic [1:0] SIG_NEG  = 2'b11;

  function automatic logic [3:0] state_pattern(input state_t s);
    case (s)
      POS:            return PAT_POS;
      ZERO_A, ZERO_B: return PAT_ZERO;
      NEG:            return PAT_NEG;
      default:        return PAT_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] state_sigma(input state_t s);
    case (s)
      POS:     return SIG_POS;
      NEG:     return SIG_NEG;
      default: return SIG_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/deadtime_leg.sv
// One half-bridge leg: gates the requested high/low switch with a dead-time delay after each target change.
// Latency: outgoing switch drops in the cycle after the request changes; incoming switch rises dead_time cycles later.
// Backpressure: none; requests are followed every cycle, an unchanged target never drops its switch.
module deadtime_leg #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_hi,
  input  logic            req_lo,
  input  logic [DT_W-1:0] dead_time,
  output logic            gate_hi,
  output logic            gate_lo
);

  logic [1:0]      req_q;
  logic [DT_W-1:0] elapsed;
  logic [DT_W-1:0] elapsed_n;
  logic            changed;
  logic            dt_done;

  assign changed = ({req_hi, req_lo} != req_q);

  // Cycles since the target last changed; restarts on a change, saturates so long segments never wrap
  always_comb begin
    elapsed_n = elapsed;
    if (changed) begin
      elapsed_n = '0;
    end else if (elapsed != '1) begin
      elapsed_n = elapsed + 1'b1;
    end
  end

  assign dt_done = (elapsed_n >= dead_time);

  // Gate register: a switch already on with an unchanged target stays on even if the dead time grew
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= 2'b00;
      elapsed <= '0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
    end else begin
      req_q   <= {req_hi, req_lo};
      elapsed <= elapsed_n;
      gate_hi <= req_hi && ((gate_hi && !changed) || dt_done);
      gate_lo <= req_lo && ((gate_lo && !changed) || dt_done);
    end
  end

endmodule

// File: rtl/three_level_modulator.sv
// Three-level full-bridge gate command generator (+1/0/-1/0) with programmable timing and per-leg dead time.
// Latency: i_EN sampled high in IDLE gives POS/o_sigma=+1 next cycle; gates follow after the latched dead time.
// Backpressure: none; i_EN low only takes effect at the end of a full period. Optional o_SYNC via THREE_LEVEL_SYNC_EN.
module three_level_modulator
  import three_level_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DT_W    = 8,
  parameter int SIGMA_W = 32
) (
  input  logic               i_CLK,
  input  logic               i_RST_n,
  input  logic               i_EN,
  input  logic [CNT_W-1:0]   i_HALF_PERIOD,
  input  logic [CNT_W-1:0]   i_ZERO_TIME,
  input  logic [DT_W-1:0]    i_DEAD_TIME,
  output logic [3:0]         o_MOSFET,
  output logic [SIGMA_W-1:0] o_sigma,
`ifdef THREE_LEVEL_SYNC_EN
  output logic               o_SYNC,
`endif
  output logic               o_BUSY
);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] seg_cnt;
  logic [CNT_W-1:0] seg_cnt_n;
  logic [CNT_W-1:0] pos_q;      // latched POS/NEG length
  logic [CNT_W-1:0] pos_n;
  logic [CNT_W-1:0] zero_q;     // latched ZERO_A/ZERO_B length
  logic [CNT_W-1:0] zero_n;
  logic [DT_W-1:0]  dt_q;
  logic [DT_W-1:0]  dt_n;
  logic             enter_pos;
  logic             period_end;
  logic [CNT_W-1:0] half_in;
  logic [CNT_W-1:0] zero_in;
  logic [CNT_W-1:0] pos_in;
  logic [3:0]       pat_n;
  logic [1:0]       sig_n;
  logic             a_hi;
  logic             a_lo;
  logic             b_hi;
  logic             b_lo;

  // Clamped timing taken from the inputs; only used at the moment POS is entered
  assign half_in = (i_HALF_PERIOD < CNT_W'(2)) ? CNT_W'(2) : i_HALF_PERIOD;
  assign zero_in = (i_ZERO_TIME >= half_in) ? (half_in - 1'b1) : i_ZERO_TIME;
  assign pos_in  = half_in - zero_in;

  // Next-state decode; seg_cnt holds the cycles left in the current segment minus one
  always_comb begin
    state_n    = state;
    seg_cnt_n  = seg_cnt;
    pos_n      = pos_q;
    zero_n     = zero_q;
    dt_n       = dt_q;
    enter_pos  = 1'b0;
    period_end = 1'b0;
    case (state)
      IDLE: enter_pos = i_EN;
      POS: begin
        if (seg_cnt != '0) begin
          seg_cnt_n = seg_cnt - 1'b1;
        end else if (zero_q == '0) begin
          state_n   = NEG;
          seg_cnt_n = pos_q - 1'b1;
        end else begin
          state_n   = ZERO_A;
          seg_cnt_n = zero_q - 1'b1;
        end
      end
      ZERO_A: begin
        if (seg_cnt != '0) begin
          seg_cnt_n = seg_cnt - 1'b1;
        end else begin
          state_n   = NEG;
          seg_cnt_n = pos_q - 1'b1;
        end
      end
      NEG: begin
        if (seg_cnt != '0) begin
          seg_cnt_n = seg_cnt - 1'b1;
        end else if (zero_q == '0) begin
          period_end = 1'b1;
        end else begin
          state_n   = ZERO_B;
          seg_cnt_n = zero_q - 1'b1;
        end
      end
      ZERO_B: begin
        if (seg_cnt != '0) begin
          seg_cnt_n = seg_cnt - 1'b1;
        end else begin
          period_end = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (period_end) begin
      if (i_EN) begin
        enter_pos = 1'b1;
      end else begin
        state_n   = IDLE;
        seg_cnt_n = '0;
      end
    end
    if (enter_pos) begin
      state_n   = POS;
      seg_cnt_n = pos_in - 1'b1;
      pos_n     = pos_in;
      zero_n    = zero_in;
      dt_n      = i_DEAD_TIME;
    end
  end

  assign pat_n = state_pattern(state_n);
  assign sig_n = state_sigma(state_n);

  // FSM, latched timing and registered sigma/busy outputs
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      state   <= IDLE;
      seg_cnt <= '0;
      pos_q   <= '0;
      zero_q  <= '0;
      dt_q    <= '0;
      o_sigma <= '0;
      o_BUSY  <= 1'b0;
    end else begin
      state   <= state_n;
      seg_cnt <= seg_cnt_n;
      pos_q   <= pos_n;
      zero_q  <= zero_n;
      dt_q    <= dt_n;
      o_sigma <= {{(SIGMA_W-2){sig_n[1]}}, sig_n};
      o_BUSY  <= (state_n != IDLE);
    end
  end

`ifdef THREE_LEVEL_SYNC_EN
  // One-cycle marker in the first cycle of every POS entry
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      o_SYNC <= 1'b0;
    end else begin
      o_SYNC <= enter_pos;
    end
  end
`endif

  // Leg A drives M0 (high) / M2 (low); leg B drives M1 (high) / M3 (low)
  deadtime_leg #(.DT_W(DT_W)) u_leg_a (
    .clk       (i_CLK),
    .rst_n     (i_RST_n),
    .req_hi    (pat_n[0]),
    .req_lo    (pat_n[2]),
    .dead_time (dt_n),
    .gate_hi   (a_hi),
    .gate_lo   (a_lo)
  );

  deadtime_leg #(.DT_W(DT_W)) u_leg_b (
    .clk       (i_CLK),
    .rst_n     (i_RST_n),
    .req_hi    (pat_n[1]),
    .req_lo    (pat_n[3]),
    .dead_time (dt_n),
    .gate_hi   (b_hi),
    .gate_lo   (b_lo)
  );

  assign o_MOSFET = {b_lo, a_lo, b_hi, a_hi};

endmodule
